acia_rx_sampler: RTL and testbench



---
 rtl/acia_rx_sampler.sv | 111 +++++++++++
 tb/tb_acia_rx_sampler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/acia_rx_sampler.sv
// 8N1 asynchronous serial receiver for the ACIA: two-flop synchronizer, per-bit
// cycle counter, and a 3-sample majority vote around mid-bit.
module acia_rx_sampler #(
  parameter int SCW     = 12,
  parameter int sym_cnt = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] rx_dat,
  output logic       rx_stb,
  output logic       rx_err,
  output logic       rx_busy
);

  localparam int HALF = sym_cnt / 2;
  localparam logic [SCW-1:0] CNT_PRE  = SCW'(HALF - 1);
  localparam logic [SCW-1:0] CNT_HALF = SCW'(HALF);
  localparam logic [SCW-1:0] CNT_MID  = SCW'(HALF + 1);
  localparam logic [SCW-1:0] CNT_LAST = SCW'(sym_cnt - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t         state, state_nxt;
  logic           rx_meta, rxs, rxs_d;
  logic [SCW-1:0] cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           smp_a, smp_b;
  logic           fall, mid, sym_end, maj, frame_done;

  // Synchronizer resets to the idle level so reset release never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop take the previous stage's old value.
      rx_meta <= rx_serial;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign fall       = rxs_d & ~rxs;
  assign mid        = (cnt == CNT_MID);
  assign sym_end    = (cnt == CNT_LAST);
  assign maj        = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);
  assign frame_done = (state == STOP) && mid;
  assign rx_busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: begin
        if (mid && maj)   state_nxt = IDLE;
        else if (sym_end) state_nxt = DATA;
      end
      DATA:  if (sym_end && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (mid) state_nxt = maj ? IDLE : BREAK;
      BREAK: if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The edge-detect cycle counts as 0, so the start bit is timed from its first low sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      smp_a   <= 1'b1;
      smp_b   <= 1'b1;
      shift   <= '0;
    end else begin
      if (state == IDLE)  cnt <= fall ? SCW'(1) : '0;
      else if (sym_end)   cnt <= '0;
      else                cnt <= cnt + SCW'(1);

      if (cnt == CNT_PRE)  smp_a <= rxs;
      if (cnt == CNT_HALF) smp_b <= rxs;

      if (state == START)                bit_idx <= '0;
      else if (state == DATA && sym_end) bit_idx <= bit_idx + 3'd1;

      if (state == DATA && mid) shift <= {maj, shift[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_dat <= 8'h00;
      rx_stb <= 1'b0;
      rx_err <= 1'b0;
    end else begin
      rx_stb <= frame_done;
      if (frame_done) begin
        rx_dat <= shift;
        rx_err <= ~maj;
      end
    end
  end

endmodule

// File: tb/tb_acia_rx_sampler.sv
// Self-checking bench for acia_rx_sampler: directed scenarios plus randomized
// frames, scored against a frame-level queue of expected (byte, error) results.
module tb_acia_rx_sampler;

  localparam int SCW  = 12;
  localparam int SYM  = 16;
  localparam int HALF = SYM / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_dat;
  logic       rx_stb, rx_err, rx_busy;

  acia_rx_sampler #(.SCW(SCW), .sym_cnt(SYM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_serial (rx_serial),
    .rx_dat    (rx_dat),
    .rx_stb    (rx_stb),
    .rx_err    (rx_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dat;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   stb_cnt = 0;
  int   last_stb_cyc = 0;
  int   prev_stb_cyc = 0;
  logic [7:0] prev_dat = 8'h00;
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every strobe must match the oldest pending frame; rx_dat may only move on a strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_stb) begin
        stb_cnt++;
        prev_stb_cyc = last_stb_cyc;
        last_stb_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_stb", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rx_dat", rx_dat, mon_e.dat);
          check("rx_err", rx_err, mon_e.err);
        end
      end else if (rx_dat !== prev_dat) begin
        check("dat_hold", rx_dat, prev_dat);
      end
    end
    prev_dat = rx_dat;
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      rx_serial = v;
    end
  endtask

  // One 8N1 frame at `per` clocks/bit; stop_low>0 holds the stop bit low for that many
  // symbols (framing error); inv_bit>=0 flips one cycle at the middle of that data bit.
  task automatic send_frame(input logic [7:0] b, input int per, input int stop_low,
                            input int inv_bit);
    logic [9:0] bits;
    logic       v;
    bits = {1'b1, b, 1'b0};
    exp_q.push_back('{dat: b, err: (stop_low > 0)});
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < per; c++) begin
        v = bits[k];
        if (k == 9 && stop_low > 0) v = 1'b0;
        if (k == inv_bit + 1 && c == per / 2) v = ~v;
        @(negedge clk);
        rx_serial = v;
      end
    end
    if (stop_low > 1) drive(1'b0, (stop_low - 1) * per);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dat"},  rx_dat,  8'h00);
    check({tag, "_stb"},  rx_stb,  1'b0);
    check({tag, "_err"},  rx_err,  1'b0);
    check({tag, "_busy"}, rx_busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n_frames;
    logic [7:0] b;
    logic [9:0] bits81;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    drive(1'b1, 8);

    // Basic byte
    s0 = stb_cnt;
    send_frame(8'hA5, SYM, 0, -1);
    drive(1'b1, 10);
    check("basic_strobes", stb_cnt - s0, 1);
    check("basic_busy", rx_busy, 0);
    check("basic_pending", exp_q.size(), 0);

    // Back-to-back frames, zero idle
    send_frame(8'h00, SYM, 0, -1);
    send_frame(8'hFF, SYM, 0, -1);
    drive(1'b1, 10);
    check("b2b_gap_in_range",
          (last_stb_cyc - prev_stb_cyc >= 10*SYM - 1) && (last_stb_cyc - prev_stb_cyc <= 10*SYM + 1), 1);
    check("b2b_pending", exp_q.size(), 0);

    // Idle-line glitch: no strobe, back to idle
    s0 = stb_cnt;
    drive(1'b0, 3);
    drive(1'b1, 20);
    check("glitch_strobes", stb_cnt - s0, 0);
    check("glitch_busy", rx_busy, 0);

    // Inverted mid-bit sample outvoted
    send_frame(8'h55, SYM, 0, 3);
    drive(1'b1, 10);
    check("midglitch_pending", exp_q.size(), 0);

    // Framing error with a long break, then a good frame
    s0 = stb_cnt;
    send_frame(8'h3C, SYM, 20, -1);
    check("break_strobes_low", stb_cnt - s0, 1);
    drive(1'b1, 20);
    check("break_strobes_high", stb_cnt - s0, 1);
    check("break_err_status", rx_err, 1);
    send_frame(8'h12, SYM, 0, -1);
    drive(1'b1, 10);
    check("recover_err", rx_err, 0);
    check("recover_dat", rx_dat, 8'h12);

    // Baud tolerance
    send_frame(8'hC3, SYM - 1, 0, -1);
    drive(1'b1, 20);
    send_frame(8'hC3, SYM + 1, 0, -1);
    drive(1'b1, 20);
    check("baud_pending", exp_q.size(), 0);
    check("baud_err", rx_err, 0);

    // Reset mid-frame during bit 4 of 8'h81
    bits81 = {1'b1, 8'h81, 1'b0};
    for (int k = 0; k < 5; k++) drive(bits81[k], SYM);
    drive(bits81[5], HALF);
    @(negedge clk);
    rst_n = 1'b0;
    rx_serial = 1'b1;
    #1;
    check_reset_outputs("midreset");
    drive(1'b1, 4);
    rst_n = 1'b1;
    drive(1'b1, 10);
    s0 = stb_cnt;
    send_frame(8'h7E, SYM, 0, -1);
    drive(1'b1, 10);
    check("postreset_strobes", stb_cnt - s0, 1);
    check("postreset_dat", rx_dat, 8'h7E);

    // Randomized traffic
    s0 = stb_cnt;
    n_frames = 0;
    for (int i = 0; i < 30; i++) begin
      int kind;
      b = 8'($urandom);
      kind = $urandom_range(0, 7);
      if (kind == 1) begin
        drive(1'b1, 4);
        drive(1'b0, $urandom_range(1, HALF - 1));
        drive(1'b1, HALF + 6);
      end
      if (kind == 0) begin
        send_frame(b, SYM, $urandom_range(1, 2), -1);
        drive(1'b1, $urandom_range(3, 10));
      end else begin
        send_frame(b, SYM, 0, (kind == 2) ? $urandom_range(0, 7) : -1);
        drive(1'b1, $urandom_range(0, 6));
      end
      n_frames++;
    end
    drive(1'b1, 20);
    check("rand_strobes", stb_cnt - s0, n_frames);
    check("rand_pending", exp_q.size(), 0);
    check("rand_busy", rx_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
